ddr_burst_writer: RTL and testbench
===================================

DDR_BURST_WRITER -- requirements
Module: ddr_burst_writer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, MCB write-port width in bits (32, 64 or 128).
REQ-002 SHALL have parameter BURST_LEN, default 64, words per full burst (1..64).
REQ-003 SHALL have parameter ADDR_W, default 30, byte-address width.
REQ-004 SHALL have port ddr_usrclk  in  1  sole clock.
REQ-005 SHALL have port ddr_usrreset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start_i  in  1  one-cycle capture start pulse.
REQ-007 SHALL have port stop_i  in  1  one-cycle flush request pulse.
REQ-008 SHALL have port ring_mode_i  in  1  1 = wrap within region, 0 = one-shot.
REQ-009 SHALL have port base_addr_i  in  ADDR_W  region base byte address, burst-aligned.
REQ-010 SHALL have port limit_bytes_i  in  ADDR_W  region size in bytes, multiple of burst bytes; 0 means 2^ADDR_W.
REQ-011 SHALL have ports src_dout_i (in, DATA_W), src_empty_i (in, 1), src_has_burst_i (in, 1) and src_rd_en_o (out, 1), for a first-word-fall-through source FIFO.
REQ-012 SHALL have ports mcb_wr_en_o (out, 1), mcb_wr_data_o (out, DATA_W), mcb_wr_mask_o (out, DATA_W/8) and mcb_wr_full_i (in, 1).
REQ-013 SHALL have ports mcb_cmd_en_o (out, 1), mcb_cmd_instr_o (out, 3), mcb_cmd_bl_o (out, 6), mcb_cmd_byte_addr_o (out, ADDR_W) and mcb_cmd_full_i (in, 1).
REQ-014 SHALL have ports busy_o (out, 1), done_o (out, 1, sticky), wrapped_o (out, 1, sticky) and next_addr_o (out, ADDR_W).

Function
REQ-015 SHALL implement states IDLE, WAIT_DATA, WRITE, CMD, FLUSH and DONE.
REQ-016 SHALL, in IDLE, on start_i clear offset, done_o and wrapped_o and go to WAIT_DATA; stop_i in IDLE is ignored.
REQ-017 SHALL move WAIT_DATA->WRITE when src_has_burst_i=1 and mcb_wr_full_i=0, and WAIT_DATA->FLUSH on stop_i.
REQ-018 SHALL drive mcb_wr_en_o = src_rd_en_o = 1 combinationally in WRITE/FLUSH when mcb_wr_full_i=0, src_empty_i=0 and words<BURST_LEN, with mcb_wr_data_o = src_dout_i (zero added latency).
REQ-019 SHALL drive mcb_wr_mask_o = 0 and mcb_cmd_instr_o = 3'b000 constantly.
REQ-020 SHALL go WRITE->CMD after BURST_LEN words; a stop_i seen during WRITE is latched and serviced after CMD.
REQ-021 SHALL, in CMD, pulse mcb_cmd_en_o for exactly one cycle when mcb_cmd_full_i=0, with mcb_cmd_bl_o = words-1 and mcb_cmd_byte_addr_o = base_addr_i + offset; it holds otherwise.
REQ-022 SHALL advance offset by words*DATA_W/8 after each command, and when the new offset equals the region size: ring mode sets offset 0 and wrapped_o; one-shot goes to DONE.
REQ-023 SHALL, in FLUSH, drain up to BURST_LEN words until src_empty_i, then issue CMD with the partial length, or go straight to DONE when 0 words were drained.
REQ-024 SHALL, in DONE, set done_o and return to IDLE on the next cycle.
REQ-025 SHALL drive busy_o = 1 in every state except IDLE, and next_addr_o = base_addr_i + offset.
REQ-026 SHALL ignore start_i while busy_o=1.

Reset
REQ-027 SHALL, on ddr_usrreset, asynchronously enter IDLE and zero every output, the offset, the word count, the stop latch and the statistics counters, including mid-burst.

Configuration
REQ-028 SHALL, with DDRWR_STATS_EN defined, add outputs burst_cnt_o (32) counting issued commands and stall_cnt_o (32) counting WRITE cycles blocked by src_empty_i or mcb_wr_full_i, both saturating and cleared on start_i.
REQ-029 SHALL, without DDRWR_STATS_EN, keep both ports tied to zero and add no counter logic.

Structure
REQ-030 SHALL take state encodings and the MCB instruction constants (WRITE=3'b000, READ=3'b001) from shared package ddr_pkg.
REQ-031 SHALL contain one sub-module, ddr_wr_addr_gen, holding the offset, the wrap/end compare and next_addr_o.

Verification
REQ-032 SHALL check: BURST_LEN=64, base=0, limit=1024, one-shot, 256 words -> 4 commands at 0, 256, 512, 768, each bl=63, then done_o=1.
REQ-033 SHALL check: the same setup in ring mode with 320 words -> 5th command at address 0 and wrapped_o=1.
REQ-034 SHALL check: 64 words then stop_i with 10 more words -> commands bl=63 at 0 and bl=9 at 256, then done_o.
REQ-035 SHALL check: mcb_wr_full_i toggled every other cycle in WRITE -> exactly 64 wr_en pulses, with data order preserved.
REQ-036 SHALL check: ddr_usrreset asserted after word 30 -> all outputs 0 and state IDLE in the same cycle.
REQ-037 SHALL check: with DDRWR_STATS_EN, 3 bursts with 5 full cycles -> burst_cnt_o=3 and stall_cnt_o=5.

Source files
------------

// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - shared FSM states and MCB command constants for the DDR burst writer
package ddr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DATA,
    ST_WRITE,
    ST_CMD,
    ST_FLUSH,
    ST_DONE
  } wr_state_t;

  localparam logic [2:0] MCB_INSTR_WRITE = 3'b000;
  localparam logic [2:0] MCB_INSTR_READ  = 3'b001;

endpackage

// File: rtl/ddr_wr_addr_gen.sv
// rtl/ddr_wr_addr_gen.sv - region offset tracking, wrap/end detection and next write address
module ddr_wr_addr_gen #(
  parameter int ADDR_W = 30
) (
  input  logic              ddr_usrclk,
  input  logic              ddr_usrreset,
  input  logic              clr,
  input  logic              adv,
  input  logic              ring_mode_i,
  input  logic [ADDR_W-1:0] inc,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] limit_bytes_i,
  output logic              at_end,
  output logic              wrapped_o,
  output logic [ADDR_W-1:0] next_addr_o
);

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W:0]   sum;
  logic [ADDR_W:0]   region;

  // one extra bit so a zero limit can stand for the full 2^ADDR_W space
  assign sum         = {1'b0, offset} + {1'b0, inc};
  assign region      = {(limit_bytes_i == '0), limit_bytes_i};
  assign at_end      = (sum == region);
  assign next_addr_o = base_addr_i + offset;

  always_ff @(posedge ddr_usrclk or posedge ddr_usrreset) begin
    if (ddr_usrreset) begin
      offset    <= '0;
      wrapped_o <= 1'b0;
    end else if (clr) begin
      offset    <= '0;
      wrapped_o <= 1'b0;
    end else if (adv) begin
      if (at_end && ring_mode_i) begin
        offset    <= '0;
        wrapped_o <= 1'b1;
      end else begin
        offset <= sum[ADDR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ddr_burst_writer.sv
// rtl/ddr_burst_writer.sv - streams a FWFT source FIFO into MCB write bursts over a ring/one-shot region
// Optional statistics counters are built when DDRWR_STATS_EN is defined.
module ddr_burst_writer import ddr_pkg::*; #(
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 64,
  parameter int ADDR_W    = 30
) (
  input  logic                ddr_usrclk,
  input  logic                ddr_usrreset,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                ring_mode_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic [ADDR_W-1:0]   limit_bytes_i,
  input  logic [DATA_W-1:0]   src_dout_i,
  input  logic                src_empty_i,
  input  logic                src_has_burst_i,
  output logic                src_rd_en_o,
  output logic                mcb_wr_en_o,
  output logic [DATA_W-1:0]   mcb_wr_data_o,
  output logic [DATA_W/8-1:0] mcb_wr_mask_o,
  input  logic                mcb_wr_full_i,
  output logic                mcb_cmd_en_o,
  output logic [2:0]          mcb_cmd_instr_o,
  output logic [5:0]          mcb_cmd_bl_o,
  output logic [ADDR_W-1:0]   mcb_cmd_byte_addr_o,
  input  logic                mcb_cmd_full_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                wrapped_o,
  output logic [ADDR_W-1:0]   next_addr_o,
  output logic [31:0]         burst_cnt_o,
  output logic [31:0]         stall_cnt_o
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  wr_state_t         state, state_nxt;
  logic [CNT_W-1:0]  words;
  logic              stop_pend;
  logic              flushing;
  logic              done_q;
  logic              wr_fire;
  logic              cmd_fire;
  logic              at_end;
  logic              start_ok;
  logic [ADDR_W-1:0] inc;

  assign start_ok = (state == ST_IDLE) && start_i;
  assign wr_fire  = ((state == ST_WRITE) || (state == ST_FLUSH)) && !mcb_wr_full_i &&
                    !src_empty_i && (words < CNT_W'(BURST_LEN));
  assign cmd_fire = (state == ST_CMD) && !mcb_cmd_full_i;
  assign inc      = ADDR_W'(words) * ADDR_W'(DATA_W / 8);

  assign src_rd_en_o         = wr_fire;
  assign mcb_wr_en_o         = wr_fire;
  assign mcb_wr_data_o       = wr_fire ? src_dout_i : '0;
  assign mcb_wr_mask_o       = '0;
  assign mcb_cmd_instr_o     = MCB_INSTR_WRITE;
  assign mcb_cmd_en_o        = cmd_fire;
  assign mcb_cmd_bl_o        = (state == ST_CMD) ? 6'(words - CNT_W'(1)) : '0;
  assign mcb_cmd_byte_addr_o = (state == ST_CMD) ? next_addr_o : '0;
  assign busy_o              = (state != ST_IDLE);
  assign done_o              = done_q;

  ddr_wr_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .ddr_usrclk    (ddr_usrclk),
    .ddr_usrreset  (ddr_usrreset),
    .clr           (start_ok),
    .adv           (cmd_fire),
    .ring_mode_i   (ring_mode_i),
    .inc           (inc),
    .base_addr_i   (base_addr_i),
    .limit_bytes_i (limit_bytes_i),
    .at_end        (at_end),
    .wrapped_o     (wrapped_o),
    .next_addr_o   (next_addr_o)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (start_i) state_nxt = ST_WAIT_DATA;
      ST_WAIT_DATA: begin
        if (stop_i)                                  state_nxt = ST_FLUSH;
        else if (src_has_burst_i && !mcb_wr_full_i)  state_nxt = ST_WRITE;
      end
      ST_WRITE:     if (wr_fire && (words == CNT_W'(BURST_LEN - 1))) state_nxt = ST_CMD;
      ST_FLUSH: begin
        if ((words == CNT_W'(BURST_LEN)) || src_empty_i)
          state_nxt = (words == '0) ? ST_DONE : ST_CMD;
      end
      ST_CMD: begin
        // a flush burst always ends the capture; otherwise a pending stop drains the remainder
        if (cmd_fire) begin
          if (flushing || (at_end && !ring_mode_i)) state_nxt = ST_DONE;
          else if (stop_pend || stop_i)             state_nxt = ST_FLUSH;
          else                                      state_nxt = ST_WAIT_DATA;
        end
      end
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ddr_usrclk or posedge ddr_usrreset) begin
    if (ddr_usrreset) begin
      state     <= ST_IDLE;
      words     <= '0;
      stop_pend <= 1'b0;
      flushing  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wr_fire)                            words <= words + CNT_W'(1);
      else if (cmd_fire || start_ok)          words <= '0;
      if (((state == ST_WRITE) || (state == ST_CMD)) && stop_i) stop_pend <= 1'b1;
      if ((state_nxt == ST_FLUSH) && (state != ST_FLUSH)) begin
        flushing  <= 1'b1;
        stop_pend <= 1'b0;
      end
      if (start_ok || (state == ST_DONE)) begin
        flushing  <= 1'b0;
        stop_pend <= 1'b0;
      end
      if (start_ok)              done_q <= 1'b0;
      else if (state == ST_DONE) done_q <= 1'b1;
    end
  end

`ifdef DDRWR_STATS_EN
  logic [31:0] burst_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge ddr_usrclk or posedge ddr_usrreset) begin
    if (ddr_usrreset) begin
      burst_cnt <= '0;
      stall_cnt <= '0;
    end else if (start_ok) begin
      burst_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (cmd_fire && (burst_cnt != '1)) burst_cnt <= burst_cnt + 32'd1;
      if ((state == ST_WRITE) && (src_empty_i || mcb_wr_full_i) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign burst_cnt_o = burst_cnt;
  assign stall_cnt_o = stall_cnt;
`else
  assign burst_cnt_o = '0;
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ddr_burst_writer.sv
// tb/tb_ddr_burst_writer.sv - scoreboard bench for ddr_burst_writer with a FWFT source model
module tb_ddr_burst_writer;

  localparam int DATA_W    = 32;
  localparam int BURST_LEN = 64;
  localparam int ADDR_W    = 30;

  logic                ddr_usrclk = 1'b0;
  logic                ddr_usrreset;
  logic                start_i, stop_i, ring_mode_i;
  logic [ADDR_W-1:0]   base_addr_i, limit_bytes_i;
  logic [DATA_W-1:0]   src_dout_i;
  logic                src_empty_i, src_has_burst_i, src_rd_en_o;
  logic                mcb_wr_en_o, mcb_wr_full_i;
  logic [DATA_W-1:0]   mcb_wr_data_o;
  logic [DATA_W/8-1:0] mcb_wr_mask_o;
  logic                mcb_cmd_en_o, mcb_cmd_full_i;
  logic [2:0]          mcb_cmd_instr_o;
  logic [5:0]          mcb_cmd_bl_o;
  logic [ADDR_W-1:0]   mcb_cmd_byte_addr_o, next_addr_o;
  logic                busy_o, done_o, wrapped_o;
  logic [31:0]         burst_cnt_o, stall_cnt_o;

  always #5 ddr_usrclk = ~ddr_usrclk;

  ddr_burst_writer #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .ADDR_W(ADDR_W)) dut (
    .ddr_usrclk(ddr_usrclk), .ddr_usrreset(ddr_usrreset),
    .start_i(start_i), .stop_i(stop_i), .ring_mode_i(ring_mode_i),
    .base_addr_i(base_addr_i), .limit_bytes_i(limit_bytes_i),
    .src_dout_i(src_dout_i), .src_empty_i(src_empty_i),
    .src_has_burst_i(src_has_burst_i), .src_rd_en_o(src_rd_en_o),
    .mcb_wr_en_o(mcb_wr_en_o), .mcb_wr_data_o(mcb_wr_data_o),
    .mcb_wr_mask_o(mcb_wr_mask_o), .mcb_wr_full_i(mcb_wr_full_i),
    .mcb_cmd_en_o(mcb_cmd_en_o), .mcb_cmd_instr_o(mcb_cmd_instr_o),
    .mcb_cmd_bl_o(mcb_cmd_bl_o), .mcb_cmd_byte_addr_o(mcb_cmd_byte_addr_o),
    .mcb_cmd_full_i(mcb_cmd_full_i), .busy_o(busy_o), .done_o(done_o),
    .wrapped_o(wrapped_o), .next_addr_o(next_addr_o),
    .burst_cnt_o(burst_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [5:0]        bl;
  } cmd_t;

  int                total = 0, bad = 0;
  int                wr_seen = 0, cmd_seen = 0;
  int                full_mode = 0;  // 0 driven by main, 1 toggle, 2 random
  logic              rd_pending = 1'b0;
  logic [DATA_W-1:0] src_q[$];
  logic [DATA_W-1:0] exp_data[$];
  cmd_t              exp_cmd[$];
  cmd_t              mc;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endfunction

  task automatic refresh_src();
    src_empty_i     = (src_q.size() == 0);
    src_has_burst_i = (src_q.size() >= BURST_LEN);
    src_dout_i      = src_empty_i ? '0 : src_q[0];
  endtask

  // reference: expected command list from region arithmetic, data = words in push order
  task automatic load(int n, bit ring, logic [ADDR_W-1:0] base, logic [ADDR_W-1:0] limit, bit stop_rem);
    longint region, off;
    bit ended;
    cmd_t c;
    logic [DATA_W-1:0] w;
    region = (limit == 0) ? (64'd1 << ADDR_W) : longint'(limit);
    off = 0;
    ended = 0;
    for (int i = 0; i < n / BURST_LEN && !ended; i++) begin
      c.addr = ADDR_W'(longint'(base) + off);
      c.bl   = 6'(BURST_LEN - 1);
      exp_cmd.push_back(c);
      off += BURST_LEN * (DATA_W / 8);
      if (off == region) begin
        if (ring) off = 0;
        else ended = 1;
      end
    end
    if (stop_rem && (n % BURST_LEN) > 0 && !ended) begin
      c.addr = ADDR_W'(longint'(base) + off);
      c.bl   = 6'((n % BURST_LEN) - 1);
      exp_cmd.push_back(c);
    end
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      src_q.push_back(w);
      exp_data.push_back(w);
    end
    refresh_src();
    base_addr_i   = base;
    limit_bytes_i = limit;
    ring_mode_i   = ring;
    wr_seen       = 0;
    cmd_seen      = 0;
  endtask

  always @(negedge ddr_usrclk) rd_pending = src_rd_en_o;

  always @(posedge ddr_usrclk) begin
    #1;
    if (rd_pending && src_q.size() > 0) void'(src_q.pop_front());
    rd_pending = 1'b0;
    refresh_src();
    case (full_mode)
      1: mcb_wr_full_i = ~mcb_wr_full_i;
      2: begin
        mcb_wr_full_i  = ($urandom_range(0, 3) == 0);
        mcb_cmd_full_i = ($urandom_range(0, 2) == 0);
      end
      default: ;
    endcase
  end

  always @(negedge ddr_usrclk) begin
    if (!ddr_usrreset) begin
      if (mcb_wr_en_o) begin
        wr_seen++;
        check("rd_en_with_wr_en", src_rd_en_o, 1);
        check("wr_mask", mcb_wr_mask_o, 0);
        if (exp_data.size() == 0) check("unexpected_write", 1, 0);
        else check("wr_data", mcb_wr_data_o, exp_data.pop_front());
      end
      if (mcb_cmd_en_o) begin
        cmd_seen++;
        check("cmd_instr", mcb_cmd_instr_o, 0);
        if (exp_cmd.size() == 0) check("unexpected_cmd", 1, 0);
        else begin
          mc = exp_cmd.pop_front();
          check("cmd_addr", mcb_cmd_byte_addr_o, mc.addr);
          check("cmd_bl", mcb_cmd_bl_o, mc.bl);
        end
      end
    end
  end

  task automatic tick();
    @(posedge ddr_usrclk);
    #2;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
  endtask

  task automatic wait_cmds(int n, string name);
    int b = 0;
    while (cmd_seen < n && b < 4000) begin tick(); b++; end
    check(name, cmd_seen, n);
  endtask

  task automatic wait_wr(int n, string name);
    int b = 0;
    while (wr_seen < n && b < 4000) begin tick(); b++; end
    if (wr_seen < n) check(name, wr_seen, n);
  endtask

  task automatic wait_done(string name);
    int b = 0;
    while (done_o !== 1'b1 && b < 4000) begin tick(); b++; end
    check(name, done_o, 1);
    check({name, "_idle"}, busy_o, 0);
  endtask

  task automatic check_drained(string name);
    check({name, "_data_left"}, exp_data.size(), 0);
    check({name, "_cmd_left"}, exp_cmd.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ddr_usrreset = 1'b1;
    start_i = 0; stop_i = 0; ring_mode_i = 0;
    base_addr_i = 0; limit_bytes_i = 0;
    mcb_wr_full_i = 0; mcb_cmd_full_i = 0;
    refresh_src();
    repeat (3) tick();
    check("rst_busy", busy_o, 0);
    check("rst_wr_en", mcb_wr_en_o, 0);
    check("rst_cmd_en", mcb_cmd_en_o, 0);
    check("rst_done", done_o, 0);
    check("rst_wrapped", wrapped_o, 0);
    ddr_usrreset = 1'b0;
    tick();

    pulse_stop();
    tick();
    check("stop_in_idle_ignored", busy_o, 0);

    // one-shot 256 words with random back-pressure
    load(256, 0, 0, 1024, 0);
    full_mode = 2;
    pulse_start();
    check("t1_busy", busy_o, 1);
    wait_cmds(4, "t1_cmds");
    wait_done("t1_done");
    full_mode = 0; mcb_wr_full_i = 0; mcb_cmd_full_i = 0;
    check("t1_wrapped", wrapped_o, 0);
    check_drained("t1");

    // ring 320 words, stray start mid-run must be ignored
    load(320, 1, 0, 1024, 0);
    full_mode = 2;
    pulse_start();
    check("t2_done_cleared", done_o, 0);
    wait_cmds(2, "t2_cmds_a");
    pulse_start();
    wait_cmds(5, "t2_cmds");
    full_mode = 0; mcb_wr_full_i = 0; mcb_cmd_full_i = 0;
    repeat (3) tick();
    check("t2_wrapped", wrapped_o, 1);
    check("t2_next_addr", next_addr_o, 256);
    check("t2_busy", busy_o, 1);
    pulse_stop();
    wait_done("t2_done");
    check("t2_cmd_total", cmd_seen, 5);
    check_drained("t2");

    // 64 words then stop drains 10
    load(74, 0, 0, 1024, 1);
    pulse_start();
    wait_cmds(1, "t3_cmds_a");
    repeat (3) tick();
    pulse_stop();
    wait_done("t3_done");
    check("t3_cmd_total", cmd_seen, 2);
    check_drained("t3");

    // stop latched while WRITE is mid-burst
    load(69, 0, 0, 1024, 1);
    pulse_start();
    wait_wr(20, "t3b_wr");
    pulse_stop();
    wait_done("t3b_done");
    check("t3b_cmd_total", cmd_seen, 2);
    check_drained("t3b");

    // write-full toggling, non-zero base
    load(64, 0, 30'h1000, 1024, 0);
    full_mode = 1;
    pulse_start();
    wait_cmds(1, "t4_cmds");
    full_mode = 0; mcb_wr_full_i = 0;
    tick();
    check("t4_wr_pulses", wr_seen, 64);
    check("t4_next_addr", next_addr_o, 30'h1100);
    pulse_stop();
    wait_done("t4_done");
    check_drained("t4");

    // reset mid-burst
    load(64, 0, 0, 1024, 0);
    pulse_start();
    wait_wr(30, "t5_wr");
    ddr_usrreset = 1'b1;
    #1;
    check("t5_wr_en", mcb_wr_en_o, 0);
    check("t5_rd_en", src_rd_en_o, 0);
    check("t5_wr_data", mcb_wr_data_o, 0);
    check("t5_cmd_en", mcb_cmd_en_o, 0);
    check("t5_cmd_bl", mcb_cmd_bl_o, 0);
    check("t5_cmd_addr", mcb_cmd_byte_addr_o, 0);
    check("t5_busy", busy_o, 0);
    check("t5_done", done_o, 0);
    check("t5_next_addr", next_addr_o, 0);
    check("t5_burst_cnt", burst_cnt_o, 0);
    check("t5_stall_cnt", stall_cnt_o, 0);
    src_q.delete(); exp_data.delete(); exp_cmd.delete();
    refresh_src();
    tick();
    ddr_usrreset = 1'b0;
    tick();

    // statistics: 3 bursts, 5 write-full cycles mid-burst
    load(192, 0, 0, 0, 0);
    pulse_start();
    wait_wr(10, "t6_wr");
    mcb_wr_full_i = 1'b1;
    repeat (5) tick();
    mcb_wr_full_i = 1'b0;
    wait_cmds(3, "t6_cmds");
    repeat (3) tick();
`ifdef DDRWR_STATS_EN
    check("t6_burst_cnt", burst_cnt_o, 3);
    check("t6_stall_cnt", stall_cnt_o, 5);
`else
    check("t6_burst_cnt", burst_cnt_o, 0);
    check("t6_stall_cnt", stall_cnt_o, 0);
`endif
    pulse_stop();
    wait_done("t6_done");
    check_drained("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
